// File: rtl/lcisc_issue_queue_pkg.sv
// Shared types for the lcisc issue queue: ALU opcodes and the instruction word.
package lcisc_issue_queue_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [31:0] a;
    logic [31:0] b;
  } opcode_struct;

  function automatic logic is_div_zero(opcode_struct instr);
    return (instr.opcode == DIV) && (instr.b == 32'd0);
  endfunction

endpackage

// File: rtl/lcisc_issue_queue_if.sv
// Instruction-in and result-out valid/ready streams of the issue queue.
interface lcisc_issue_queue_if #(
  parameter int unsigned TAG_W = 8
);
  import lcisc_issue_queue_pkg::*;

  logic             in_valid;
  logic             in_ready;
  opcode_struct     in_instr;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_dz;

  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_data, res_tag, res_dz
  );

  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_data, res_tag, res_dz
  );

endinterface

// File: rtl/lcisc_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
module lcisc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/test_cpu.sv
// Combinational lcisc ALU: c = a <op> b; division by zero yields 0.
module test_cpu
  import lcisc_issue_queue_pkg::*;
(
  input  opcode_struct instruction,
  output logic [31:0]  c
);
  always_comb begin
    c = '0;
    unique case (instruction.opcode)
      ADD: c = instruction.a + instruction.b;
      SUB: c = instruction.a - instruction.b;
      MUL: c = instruction.a * instruction.b;
      DIV: c = (instruction.b == 32'd0) ? 32'd0 : instruction.a / instruction.b;
      default: c = '0;
    endcase
  end
endmodule

// File: rtl/lcisc_issue_queue.sv
// Buffers instructions, issues one per cycle to the ALU and returns tagged results in order.
module lcisc_issue_queue
  import lcisc_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  lcisc_issue_queue_if.slave     bus,
  output opcode_struct           alu_instr,
  input  logic [31:0]            alu_c,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef struct packed {
    opcode_struct     instr;
    logic [TAG_W-1:0] tag;
  } issue_entry_t;

  issue_entry_t    wentry, head;
  logic            push, pop, full, empty, capture_now;
  logic [CntW-1:0] count_next;

  logic             in_ready_q, in_ready_d;
  logic [TAG_W-1:0] tag_ctr_q, tag_ctr_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic             inflight_q, inflight_d;
  opcode_struct     alu_instr_q, alu_instr_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_dz_q, res_dz_d;

  assign wentry = '{instr: bus.in_instr, tag: tag_ctr_q};

  lcisc_sync_fifo #(
    .WIDTH ($bits(issue_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    push        = bus.in_valid && in_ready_q && !flush;
    capture_now = inflight_q && (!res_valid_q || bus.res_ready);
    pop         = !empty && (!inflight_q || capture_now) && !flush;
    count_next  = flush ? '0 : fifo_count + CntW'(push) - CntW'(pop);
    // Registered ready looks at next-cycle occupancy so a full FIFO is never pushed.
    in_ready_d  = !flush && (count_next != CntW'(DEPTH));

    tag_ctr_d   = push ? tag_ctr_q + TAG_W'(1) : tag_ctr_q;
    alu_instr_d = pop ? head.instr : alu_instr_q;
    issue_tag_d = pop ? head.tag : issue_tag_q;

    inflight_d = inflight_q;
    if (flush)            inflight_d = 1'b0;
    else if (pop)         inflight_d = 1'b1;
    else if (capture_now) inflight_d = 1'b0;

    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_dz_d    = res_dz_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (capture_now) begin
      res_valid_d = 1'b1;
      res_dz_d    = is_div_zero(alu_instr_q);
      res_data_d  = res_dz_d ? 32'd0 : alu_c;
      res_tag_d   = issue_tag_q;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      tag_ctr_q   <= '0;
      issue_tag_q <= '0;
      inflight_q  <= 1'b0;
      alu_instr_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      tag_ctr_q   <= tag_ctr_d;
      issue_tag_q <= issue_tag_d;
      inflight_q  <= inflight_d;
      alu_instr_q <= alu_instr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_dz_q    <= res_dz_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_dz    = res_dz_q;
  assign alu_instr     = alu_instr_q;

endmodule
